// File: rtl/pc_pkg.sv
// Operation encodings shared by decode and the program-counter sequencer.
package pc_pkg;
  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    PC_INC  = 3'd0,
    PC_JMP  = 3'd1,
    PC_REL  = 3'd2,
    PC_CALL = 3'd3,
    PC_RET  = 3'd4
  } pc_op_e;
endpackage

// File: rtl/return_stack.sv
// Return-address LIFO; push/pop requests are dropped when full/empty.
module return_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 9,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  top_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Storage is never reset; entries at or above count are don't-care.
  logic [W-1:0]  mem_q [2**IW];
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign count_o = count_q;
  assign top_o   = mem_q[IW'(count_q - CW'(1))];

  always_comb begin
    count_d = count_q;
    if (push_ok)     count_d = count_q + CW'(1);
    else if (pop_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[IW'(count_q)] <= din_i;
  end
endmodule

// File: rtl/pc_sequencer.sv
// Program counter with INC/JMP/REL/CALL/RET and a hardware return stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W      = 9,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
  parameter int                CW          = $clog2(STACK_DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [OP_W-1:0]   op,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] offset,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] curr_instr_addr,
  output logic [CW-1:0]     stack_count,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              err_ovf,
  output logic              err_unf
);
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, stk_top;
  logic              ovf_q, unf_q;
  logic              is_call, is_ret, new_ovf, new_unf;

  assign pc_inc  = pc_q + ADDR_W'(1);
  assign is_call = en && (op == PC_CALL);
  assign is_ret  = en && (op == PC_RET);
  assign new_ovf = is_call && stack_full;
  assign new_unf = is_ret && stack_empty;

  return_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W), .CW(CW)) u_stack (
    .clk     (clk),
    .rst     (rst),
    .push_i  (is_call),
    .pop_i   (is_ret),
    .din_i   (pc_inc),
    .top_o   (stk_top),
    .count_o (stack_count),
    .full_o  (stack_full),
    .empty_o (stack_empty)
  );

  // Failed CALL/RET fall through to the next instruction.
  always_comb begin
    pc_d = pc_inc;
    if (en) begin
      case (op)
        PC_JMP:  pc_d = target;
        PC_REL:  pc_d = pc_q + offset;
        PC_CALL: pc_d = stack_full  ? pc_inc : target;
        PC_RET:  pc_d = stack_empty ? pc_inc : stk_top;
        default: pc_d = pc_inc;
      endcase
    end else begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_ADDR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= (ovf_q && !clr_err) || new_ovf;
      unf_q <= (unf_q && !clr_err) || new_unf;
    end
  end

  assign curr_instr_addr = pc_q;
  assign err_ovf         = ovf_q;
  assign err_unf         = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector table plus randomized run against a queue-based model.
module tb_pc_sequencer;
  localparam int AW = 9;
  localparam int SD = 4;
  localparam int CW = $clog2(SD+1);
  localparam int MASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst, en, clr_err;
  logic [2:0]    op;
  logic [AW-1:0] target, offset;
  logic [AW-1:0] pc;
  logic [CW-1:0] cnt;
  logic          full, empty, ovf, unf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(AW), .STACK_DEPTH(SD), .RESET_ADDR('0)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .target(target), .offset(offset),
    .clr_err(clr_err), .curr_instr_addr(pc), .stack_count(cnt),
    .stack_full(full), .stack_empty(empty), .err_ovf(ovf), .err_unf(unf)
  );

  typedef struct {
    logic     rst, en, clr;
    logic [2:0] op;
    int       tgt, off;
    int       e_pc, e_cnt;
    logic     e_ovf, e_unf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic c, input int o,
                     input int t, input int f, input int epc, input int ecnt,
                     input logic eo, input logic eu);
    vec_t v;
    v.rst = r; v.en = e; v.clr = c; v.op = 3'(o); v.tgt = t; v.off = f;
    v.e_pc = epc; v.e_cnt = ecnt; v.e_ovf = eo; v.e_unf = eu;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int epc, input int ecnt,
                           input logic eo, input logic eu);
    chk({tag, " pc"},    int'(pc),    epc);
    chk({tag, " count"}, int'(cnt),   ecnt);
    chk({tag, " full"},  int'(full),  int'(ecnt == SD));
    chk({tag, " empty"}, int'(empty), int'(ecnt == 0));
    chk({tag, " ovf"},   int'(ovf),   int'(eo));
    chk({tag, " unf"},   int'(unf),   int'(eu));
  endtask

  task automatic drive(input logic r, input logic e, input logic c,
                       input logic [2:0] o, input int t, input int f);
    rst = r; en = e; clr_err = c; op = o;
    target = AW'(t); offset = AW'(f);
    @(posedge clk); #1;
  endtask

  // Reference model state
  int m_pc;
  int m_stk[$];
  logic m_ovf, m_unf;

  task automatic model_step(input logic r, input logic e, input logic c,
                            input int o, input int t, input int f);
    if (r) begin
      m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
      return;
    end
    if (c) begin m_ovf = 0; m_unf = 0; end
    if (!e) return;
    if (o == 1) m_pc = t;
    else if (o == 2) m_pc = (m_pc + f) & MASK;
    else if (o == 3) begin
      if (m_stk.size() == SD) begin m_ovf = 1; m_pc = (m_pc + 1) & MASK; end
      else begin m_stk.push_back((m_pc + 1) & MASK); m_pc = t; end
    end else if (o == 4) begin
      if (m_stk.size() == 0) begin m_unf = 1; m_pc = (m_pc + 1) & MASK; end
      else m_pc = m_stk.pop_back();
    end else m_pc = (m_pc + 1) & MASK;
  endtask

  initial begin
    rst = 1; en = 0; clr_err = 0; op = 0; target = '0; offset = '0;

    //   rst en clr op  tgt    off    pc     cnt ovf unf
    add(1, 0, 0, 0, 0,     0,     'h000, 0, 0, 0);
    add(0, 1, 0, 0, 0,     0,     'h001, 0, 0, 0);
    add(0, 1, 0, 0, 0,     0,     'h002, 0, 0, 0);
    add(0, 1, 0, 0, 0,     0,     'h003, 0, 0, 0);
    add(0, 1, 0, 1, 'h1FF, 0,     'h1FF, 0, 0, 0);
    add(0, 1, 0, 0, 0,     0,     'h000, 0, 0, 0);
    add(0, 1, 0, 1, 'h005, 0,     'h005, 0, 0, 0);
    add(0, 1, 0, 2, 0,     'h1FD, 'h002, 0, 0, 0);
    add(0, 1, 0, 2, 0,     'h1FF, 'h001, 0, 0, 0);
    add(0, 1, 0, 6, 'h0AA, 0,     'h002, 0, 0, 0);
    add(0, 1, 0, 1, 'h010, 0,     'h010, 0, 0, 0);
    add(0, 1, 0, 3, 'h080, 0,     'h080, 1, 0, 0);
    add(0, 1, 0, 3, 'h100, 0,     'h100, 2, 0, 0);
    add(0, 1, 0, 4, 0,     0,     'h081, 1, 0, 0);
    add(0, 1, 0, 4, 0,     0,     'h011, 0, 0, 0);
    add(0, 1, 0, 3, 'h040, 0,     'h040, 1, 0, 0);
    add(0, 1, 0, 3, 'h050, 0,     'h050, 2, 0, 0);
    add(0, 1, 0, 3, 'h060, 0,     'h060, 3, 0, 0);
    add(0, 1, 0, 3, 'h070, 0,     'h070, 4, 0, 0);
    add(0, 1, 0, 3, 'h1AA, 0,     'h071, 4, 1, 0);
    add(0, 0, 0, 4, 0,     0,     'h071, 4, 1, 0);
    add(0, 1, 0, 4, 0,     0,     'h061, 3, 1, 0);
    add(1, 1, 0, 3, 'h0AA, 0,     'h000, 0, 0, 0);
    add(0, 1, 0, 1, 'h020, 0,     'h020, 0, 0, 0);
    add(0, 1, 0, 4, 0,     0,     'h021, 0, 0, 1);
    add(0, 0, 1, 4, 0,     0,     'h021, 0, 0, 0);
    add(0, 1, 1, 4, 0,     0,     'h022, 0, 0, 1);
    add(0, 0, 0, 1, 'h0AA, 0,     'h022, 0, 0, 1);
    add(0, 1, 0, 1, 'h030, 0,     'h030, 0, 0, 1);
    add(0, 1, 0, 3, 'h080, 0,     'h080, 1, 0, 1);
    add(1, 1, 0, 3, 'h090, 0,     'h000, 0, 0, 0);
    add(0, 1, 0, 1, 'h1FF, 0,     'h1FF, 0, 0, 0);
    add(0, 1, 0, 3, 'h010, 0,     'h010, 1, 0, 0);
    add(0, 1, 0, 4, 0,     0,     'h000, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].clr, vecs[i].op, vecs[i].tgt, vecs[i].off);
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_cnt,
                vecs[i].e_ovf, vecs[i].e_unf);
    end

    // Randomized phase against the queue model
    model_step(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      logic r, e, c;
      int o, t, f;
      r = ($urandom_range(0, 99) < 2);
      e = ($urandom_range(0, 99) < 88);
      c = ($urandom_range(0, 99) < 8);
      o = $urandom_range(0, 9);
      if (o > 7) o = (o == 8) ? 3 : 4;
      t = $urandom_range(0, MASK);
      f = $urandom_range(0, MASK);
      model_step(r, e, c, o, t, f);
      drive(r, e, c, 3'(o), t, f);
      check_all($sformatf("rnd%0d", i), m_pc, m_stk.size(), m_ovf, m_unf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer with absolute, relative, call and return control flow. It replaces the fixed 9-bit increment/branch counter in the core fetch path and adds a hardware return-address stack with overflow/underflow detection. The sequencer sits between the decode/branch logic, which supplies the operation and target, and instruction memory, which is addressed by `curr_instr_addr`.

## Interface
- `ADDR_W`, 9: instruction address width, 2..32.
- `STACK_DEPTH`, 4: number of return-address entries, 1..16.
- `RESET_ADDR`, 0: PC value after reset, ADDR_W bits.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous and active-high; clears PC to RESET_ADDR, empties the stack and clears the error flags.
- `en` in 1: when low, PC and stack hold and `op` is ignored.
- `op` in 3: 0 INC, 1 JMP, 2 REL, 3 CALL, 4 RET; codes 5–7 are reserved and behave as INC.
- `target` in ADDR_W: absolute destination for JMP and CALL.
- `offset` in ADDR_W: two's-complement displacement for REL.
- `clr_err` in 1: clears the sticky error flags.
- `curr_instr_addr` out ADDR_W: registered current PC.
- `stack_count` out $clog2(STACK_DEPTH+1): registered number of valid stack entries.
- `stack_full` out 1: `stack_count == STACK_DEPTH`.
- `stack_empty` out 1: `stack_count == 0`.
- `err_ovf` out 1: sticky flag; a CALL was issued while the stack was full.
- `err_unf` out 1: sticky flag; a RET was issued while the stack was empty.

## Operation
- Reset values: `curr_instr_addr` = RESET_ADDR, `stack_count` = 0, `stack_empty` = 1, `stack_full` = 0, `err_ovf` = 0, `err_unf` = 0.
- With `en` high, on each edge:
  - INC: PC <= PC+1.
  - JMP: PC <= `target`.
  - REL: PC <= PC+`offset`.
  - CALL: push PC+1, then PC <= `target`.
  - RET: PC <= top of stack, then pop.
- Address arithmetic is modulo 2^ADDR_W. PC = all-ones followed by INC gives 0. Full-width REL with offset = all-ones (−1) gives PC−1.
- The CALL return address also wraps: CALL at all-ones pushes 0.
- CALL with the stack full:
  - no push and no branch;
  - PC <= PC+1;
  - `err_ovf` is set.
- RET with the stack empty:
  - no pop;
  - PC <= PC+1;
  - `err_unf` is set.
- Stack contents beyond `stack_count` are don't-care. They are not cleared on reset.
- Error flags:
  - `clr_err` acts regardless of `en`.
  - If `clr_err` and a new error occur in the same cycle, the flag ends up set.
  - Flags never clear on their own.
- `rst` overrides `en`, `op` and `clr_err`.

## Timing
- Single-cycle: an `op` sampled at edge N is reflected on `curr_instr_addr` and `stack_count` after edge N. The next PC is computed combinationally; PC, stack pointer and flags are registered.
- `stack_full` and `stack_empty` are decoded from the registered count, so they carry no input-to-output combinational path.
- `err_*` assert in the cycle after the offending edge.
- Back-to-back CALL/RET in consecutive cycles must work with no bubble. A RET immediately after a CALL returns the just-pushed address.
- Reset asserted mid-sequence takes effect at the next edge. Any in-flight CALL is discarded: the stack ends empty.
- There are no multi-cycle paths and no handshake; upstream stalls by deasserting `en`.

## Structure
- Shared package `pc_pkg` holds the `op` encodings (PC_INC, PC_JMP, PC_REL, PC_CALL, PC_RET) and the op-width constant, so decode and the sequencer use the same values.
- Sub-module `return_stack`: a LIFO of STACK_DEPTH×ADDR_W with push/pop/count/full/empty.
  - Push and pop are qualified inside `return_stack`.
  - It has no simultaneous push and pop.
  - `pc_sequencer` owns next-PC muxing, error flags and reset.

## Test plan
- Reset with RESET_ADDR=0, then 3 INC → PC 0,1,2,3; `stack_empty`=1, both flags 0.
- ADDR_W=9, PC=0x1FF, then INC → PC=0x000. From PC=0x005, REL offset 0x1FD (−3) → PC=0x002.
- From PC=0x010: CALL target 0x080, then CALL 0x100 → `stack_count`=2. Then RET → PC=0x081, RET → PC=0x011, `stack_empty`=1.
- STACK_DEPTH=4: 4 CALLs fill the stack, `stack_full`=1. A 5th CALL at PC=p → PC=p+1, `err_ovf`=1, `stack_count`=4.
- Empty stack, RET at PC=0x020 → PC=0x021 and `err_unf`=1. `clr_err` with `en` low → flag 0. `clr_err` together with another empty RET → flag stays 1.
- With `en` low, JMP 0x0AA → PC unchanged. `rst` during CALL at PC=0x030 → PC=0 and `stack_count`=0 after the edge.
